// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU widths, control codes, requester count and the operand/response bundles.
package alu_share_arbiter_pkg;

  localparam int ALU_BITS      = 32;
  localparam int ALU_CTRL_BITS = 5;
  localparam int TAG_BITS      = 4;
  localparam int NUM_REQ       = 2;

  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_ADD = 5'd0;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SUB = 5'd1;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_AND = 5'd2;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_OR  = 5'd3;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_XOR = 5'd4;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SLL = 5'd5;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SRL = 5'd6;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SLT = 5'd7;
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BEQ = 5'd8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_EXEC = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ALU_CTRL_BITS-1:0] ctrl;
    logic [ALU_BITS-1:0]      rdata1;
    logic [ALU_BITS-1:0]      rdata2;
    logic [ALU_BITS-1:0]      imm;
    logic [ALU_BITS-1:0]      pc;
    logic                     immsrc;
    logic                     pcsrc;
    logic [TAG_BITS-1:0]      tag;
  } alu_op_t;

  typedef struct packed {
    logic [ALU_BITS-1:0] result;
    logic                is_zero;
    logic [TAG_BITS-1:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_grant.sv
// One-hot issue grant from the eligibility vector; combinational, no backpressure of its own.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin (pointer in, next pointer out); otherwise requester 1 has fixed priority.
module alu_arb_grant
  import alu_share_arbiter_pkg::*;
(
  output logic [NUM_REQ-1:0] gnt_o,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic               ptr_i,
  output logic               ptr_d_o,
`endif
  input  logic [NUM_REQ-1:0] elig_i
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_o   = elig_i;
    ptr_d_o = ptr_i;
    if (&elig_i) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
    // Prefer whichever requester was not just served.
    if (gnt_o[0]) begin
      ptr_d_o = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d_o = 1'b0;
    end
  end
`else
  always_comb begin
    gnt_o = elig_i;
    if (&elig_i) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: grant registers operands, result lands in the owner's slot one edge later.
// A requester is held off while its op is in flight or its undrained slot is full; ALU_ARB_ROUND_ROBIN_EN picks round-robin.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ALU_CTRL_BITS-1:0] req_ctrl_i,
  input  logic [NUM_REQ-1:0][ALU_BITS-1:0]      req_rdata1_i,
  input  logic [NUM_REQ-1:0][ALU_BITS-1:0]      req_rdata2_i,
  input  logic [NUM_REQ-1:0][ALU_BITS-1:0]      req_imm_i,
  input  logic [NUM_REQ-1:0][ALU_BITS-1:0]      req_pc_i,
  input  logic [NUM_REQ-1:0]                    req_immsrc_i,
  input  logic [NUM_REQ-1:0]                    req_pcsrc_i,
  input  logic [NUM_REQ-1:0][TAG_BITS-1:0]      req_tag_i,
  output logic [NUM_REQ-1:0]                    rsp_valid_o,
  input  logic [NUM_REQ-1:0]                    rsp_ready_i,
  output logic [NUM_REQ-1:0][ALU_BITS-1:0]      rsp_result_o,
  output logic [NUM_REQ-1:0]                    rsp_is_zero_o,
  output logic [NUM_REQ-1:0][TAG_BITS-1:0]      rsp_tag_o,
  output logic [ALU_BITS-1:0]                   alu_rdata1_o,
  output logic [ALU_BITS-1:0]                   alu_rdata2_o,
  output logic [ALU_BITS-1:0]                   alu_imm_o,
  output logic [ALU_BITS-1:0]                   alu_pc_o,
  output logic [ALU_CTRL_BITS-1:0]              alu_ctrl_o,
  output logic                                  alu_immsrc_o,
  output logic                                  alu_pcsrc_o,
  input  logic [ALU_BITS-1:0]                   alu_result_i,
  input  logic                                  alu_is_zero_i
);

  arb_state_e                  state_q, state_d;
  logic                        exec_id_q, exec_id_d;
  alu_op_t                     op_q, op_d;
  logic [NUM_REQ-1:0]          rsp_vld_q, rsp_vld_d;
  alu_rsp_t [NUM_REQ-1:0]      rsp_q, rsp_d;
  logic [NUM_REQ-1:0]          elig;
  logic [NUM_REQ-1:0]          gnt;
  logic                        gnt_id;

  // A slot that drains this cycle can accept the next op on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] & (~rsp_vld_q[i] | rsp_ready_i[i]) &
                ~((state_q == ARB_EXEC) && (exec_id_q == 1'(i)));
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  alu_arb_grant u_grant (
    .gnt_o   (gnt),
    .ptr_i   (ptr_q),
    .ptr_d_o (ptr_d),
    .elig_i  (elig)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  alu_arb_grant u_grant (
    .gnt_o  (gnt),
    .elig_i (elig)
  );
`endif

  assign gnt_id      = gnt[1];
  assign req_ready_o = gnt & {NUM_REQ{rst_ni}};

  always_comb begin
    state_d   = ARB_IDLE;
    exec_id_d = exec_id_q;
    op_d      = '0;
    op_d.ctrl = ALUCTRL_ADD;
    rsp_vld_d = rsp_vld_q & ~rsp_ready_i;
    rsp_d     = rsp_q;

    if (state_q == ARB_EXEC) begin
      rsp_vld_d[exec_id_q] = 1'b1;
      rsp_d[exec_id_q]     = '{result: alu_result_i, is_zero: alu_is_zero_i, tag: op_q.tag};
    end

    if (|gnt) begin
      state_d   = ARB_EXEC;
      exec_id_d = gnt_id;
      op_d      = '{ctrl:   req_ctrl_i[gnt_id],
                    rdata1: req_rdata1_i[gnt_id],
                    rdata2: req_rdata2_i[gnt_id],
                    imm:    req_imm_i[gnt_id],
                    pc:     req_pc_i[gnt_id],
                    immsrc: req_immsrc_i[gnt_id],
                    pcsrc:  req_pcsrc_i[gnt_id],
                    tag:    req_tag_i[gnt_id]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exec_id_q <= 1'b0;
      op_q      <= '{ctrl: ALUCTRL_ADD, default: '0};
      rsp_vld_q <= '0;
      rsp_q     <= '0;
    end else begin
      exec_id_q <= exec_id_d;
      op_q      <= op_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_result_o[i]  = rsp_q[i].result;
      rsp_is_zero_o[i] = rsp_q[i].is_zero;
      rsp_tag_o[i]     = rsp_q[i].tag;
    end
  end

  assign rsp_valid_o  = rsp_vld_q;
  assign alu_ctrl_o   = op_q.ctrl;
  assign alu_rdata1_o = op_q.rdata1;
  assign alu_rdata2_o = op_q.rdata2;
  assign alu_imm_o    = op_q.imm;
  assign alu_pc_o     = op_q.pc;
  assign alu_immsrc_o = op_q.immsrc;
  assign alu_pcsrc_o  = op_q.pcsrc;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter against a transaction-level model; honours ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        req_valid, req_ready, req_immsrc, req_pcsrc;
  logic [1:0][4:0]   req_ctrl;
  logic [1:0][31:0]  req_rdata1, req_rdata2, req_imm, req_pc;
  logic [1:0][3:0]   req_tag;
  logic [1:0]        rsp_valid, rsp_ready, rsp_is_zero;
  logic [1:0][31:0]  rsp_result;
  logic [1:0][3:0]   rsp_tag;
  logic [31:0]       alu_rdata1, alu_rdata2, alu_imm, alu_pc, alu_result;
  logic [4:0]        alu_ctrl;
  logic              alu_immsrc, alu_pcsrc, alu_is_zero;

  alu_share_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ctrl_i(req_ctrl),
    .req_rdata1_i(req_rdata1), .req_rdata2_i(req_rdata2), .req_imm_i(req_imm), .req_pc_i(req_pc),
    .req_immsrc_i(req_immsrc), .req_pcsrc_i(req_pcsrc), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_is_zero_o(rsp_is_zero), .rsp_tag_o(rsp_tag),
    .alu_rdata1_o(alu_rdata1), .alu_rdata2_o(alu_rdata2), .alu_imm_o(alu_imm), .alu_pc_o(alu_pc),
    .alu_ctrl_o(alu_ctrl), .alu_immsrc_o(alu_immsrc), .alu_pcsrc_o(alu_pcsrc),
    .alu_result_i(alu_result), .alu_is_zero_i(alu_is_zero)
  );

  function automatic logic [31:0] alu_fn(logic [4:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      ALUCTRL_SUB: return a - b;
      ALUCTRL_AND: return a & b;
      ALUCTRL_OR:  return a | b;
      ALUCTRL_XOR: return a ^ b;
      ALUCTRL_SLL: return a << b[4:0];
      ALUCTRL_SRL: return a >> b[4:0];
      ALUCTRL_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALUCTRL_BEQ: return a - b;
      default:     return a + b;
    endcase
  endfunction

  // Stand-in for the shared ALU instance.
  always_comb begin
    alu_result  = alu_fn(alu_ctrl, alu_pcsrc ? alu_pc : alu_rdata1, alu_immsrc ? alu_imm : alu_rdata2);
    alu_is_zero = (alu_result == 32'd0);
  end

  function automatic logic [159:0] alu_vec(logic [4:0] c, logic is, logic ps, logic [31:0] r1,
                                           logic [31:0] r2, logic [31:0] im, logic [31:0] pc);
    return {25'd0, c, is, ps, r1, r2, im, pc};
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one expected response per requester, visible from cycle e_avail on.
  logic         has_e [2];
  logic [31:0]  e_res [2];
  logic         e_zero[2];
  logic [3:0]   e_tag [2];
  int           e_avail[2];
  logic [159:0] exp_alu;
  logic         ptr_m;
  logic [1:0]   gnt_obs;
  int           cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has_e[i] = 1'b0; e_res[i] = '0; e_zero[i] = 1'b0; e_tag[i] = '0; e_avail[i] = 0;
    end
    exp_alu = alu_vec(ALUCTRL_ADD, 1'b0, 1'b0, '0, '0, '0, '0);
    ptr_m   = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [4:0] c, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [31:0] pc, input logic is, input logic ps,
                        input logic [3:0] tg);
    req_ctrl[i] = c; req_rdata1[i] = r1; req_rdata2[i] = r2; req_imm[i] = im; req_pc[i] = pc;
    req_immsrc[i] = is; req_pcsrc[i] = ps; req_tag[i] = tg;
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  task automatic rand_op(input int i);
    set_op(i, 5'($urandom_range(0, 8)), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  // Caller drives inputs just after a rising edge; this checks mid-cycle and advances one edge.
  task automatic run_cycle();
    logic [1:0] rv, elig, g;
    logic       pref;
    logic [31:0] a, b;
    int w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) rv[i] = has_e[i] && (e_avail[i] <= cyc);
    check_eq("rsp_valid", rsp_valid, rv);
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        check_eq($sformatf("rsp_result%0d", i), rsp_result[i], e_res[i]);
        check_eq($sformatf("rsp_is_zero%0d", i), rsp_is_zero[i], e_zero[i]);
        check_eq($sformatf("rsp_tag%0d", i), rsp_tag[i], e_tag[i]);
      end
      elig[i] = req_valid[i] && (!has_e[i] || (rv[i] && rsp_ready[i]));
    end
    pref = RR ? ptr_m : 1'b1;
    g = elig;
    if (&elig) g = pref ? 2'b10 : 2'b01;
    gnt_obs = req_ready;
    check_eq("req_ready", req_ready, g);
    check_eq("alu_operands", alu_vec(alu_ctrl, alu_immsrc, alu_pcsrc, alu_rdata1, alu_rdata2, alu_imm, alu_pc), exp_alu);

    for (int i = 0; i < 2; i++) if (rv[i] && rsp_ready[i]) has_e[i] = 1'b0;
    exp_alu = alu_vec(ALUCTRL_ADD, 1'b0, 1'b0, '0, '0, '0, '0);
    if (g != 2'b00) begin
      w = g[1] ? 1 : 0;
      a = req_pcsrc[w] ? req_pc[w] : req_rdata1[w];
      b = req_immsrc[w] ? req_imm[w] : req_rdata2[w];
      has_e[w]   = 1'b1;
      e_avail[w] = cyc + 2;
      e_res[w]   = alu_fn(req_ctrl[w], a, b);
      e_zero[w]  = (e_res[w] == 32'd0);
      e_tag[w]   = req_tag[w];
      exp_alu    = alu_vec(req_ctrl[w], req_immsrc[w], req_pcsrc[w], req_rdata1[w], req_rdata2[w], req_imm[w], req_pc[w]);
      ptr_m      = (w == 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 2'b00);
    check_eq("rst_rsp_data", {rsp_result, rsp_is_zero, rsp_tag}, '0);
    check_eq("rst_alu", alu_vec(alu_ctrl, alu_immsrc, alu_pcsrc, alu_rdata1, alu_rdata2, alu_imm, alu_pc),
             alu_vec(ALUCTRL_ADD, 1'b0, 1'b0, '0, '0, '0, '0));
    check_eq("rst_req_ready", req_ready, 2'b00);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] prev;
    req_valid = 2'b11; rsp_ready = 2'b00;
    set_op(0, ALUCTRL_ADD, 1, 2, 3, 4, 0, 0, 1);
    set_op(1, ALUCTRL_SUB, 5, 6, 7, 8, 0, 0, 2);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_and_check();

    // Requester 0 alone: ADD 5+7, tag 3.
    req_valid = 2'b01;
    set_op(0, ALUCTRL_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 4'd3);
    run_cycle();
    check_eq("t1_not_yet", rsp_valid[0], 1'b0);
    req_valid = 2'b00;
    run_cycle();
    check_eq("t1_valid", rsp_valid[0], 1'b1);
    check_eq("t1_result", rsp_result[0], 32'd12);
    check_eq("t1_tag", rsp_tag[0], 4'd3);
    check_eq("t1_zero", rsp_is_zero[0], 1'b0);
    rsp_ready = 2'b01;
    run_cycle();

    // Requester 1 BEQ equal, then unequal issued on the drain cycle.
    rsp_ready = 2'b00; req_valid = 2'b10;
    set_op(1, ALUCTRL_BEQ, 32'h1234, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 4'd9);
    run_cycle();
    req_valid = 2'b00;
    run_cycle();
    check_eq("t2_eq_zero", rsp_is_zero[1], 1'b1);
    rsp_ready = 2'b10; req_valid = 2'b10;
    set_op(1, ALUCTRL_BEQ, 32'h1234, 32'h1235, 32'd0, 32'd0, 1'b0, 1'b0, 4'd10);
    run_cycle();
    check_eq("t2_regrant", gnt_obs, 2'b10);
    rsp_ready = 2'b00; req_valid = 2'b00;
    run_cycle();
    check_eq("t2_ne_zero", rsp_is_zero[1], 1'b0);
    rsp_ready = 2'b10;
    run_cycle();

    // Both requesting every cycle with immediate consumption: grants alternate.
    rsp_ready = 2'b11; req_valid = 2'b11;
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      rand_op(0); rand_op(1);
      run_cycle();
      if (k > 0) check_eq("t3_alternate", gnt_obs ^ prev, 2'b11);
      prev = gnt_obs;
    end
    req_valid = 2'b00;
    repeat (3) run_cycle();

    // Slot 0 held full: req0 blocked, req1 still served, then same-cycle regrant on release.
    rsp_ready = 2'b00; req_valid = 2'b01;
    rand_op(0);
    run_cycle();
    req_valid = 2'b00;
    run_cycle();
    rsp_ready = 2'b10; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rand_op(0); rand_op(1);
      run_cycle();
      check_eq("t4_req0_blocked", gnt_obs[0], 1'b0);
    end
    rsp_ready = 2'b11; req_valid = 2'b01;
    rand_op(0);
    run_cycle();
    check_eq("t4_regrant", gnt_obs, 2'b01);
    req_valid = 2'b00;
    repeat (3) run_cycle();

    // Reset while executing with slot 1 full.
    rsp_ready = 2'b00; req_valid = 2'b10;
    rand_op(1);
    run_cycle();
    req_valid = 2'b00;
    run_cycle();
    req_valid = 2'b01;
    rand_op(0);
    run_cycle();
    req_valid = 2'b11;
    reset_and_check();
    rand_op(0); rand_op(1);
    run_cycle();
    check_eq("t5_first_grant", gnt_obs, RR ? 2'b01 : 2'b10);
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (3) run_cycle();

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      rand_op(0); rand_op(1);
      if ($urandom_range(0, 199) == 0) reset_and_check();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
